alu_result_checker: RTL and testbench
=====================================

# alu_result_checker

Synthesizable self-checking monitor for the 6-bit ALU. It accepts streamed {a, b, opcode, result} records over a valid/ready handshake and recomputes the expected ALU output internally. It counts tests and failures and latches the first mismatch for on-board readout. It sits on the ALU output side, opposite the stimulus source, so directed test campaigns can run in hardware.

## Interface
- CNT_W, 8, width of test and fail counters (saturating)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: clear counters and error record, enter RUN
- in_valid  in  1  record valid
- in_ready  out  1  checker can accept a record
- in_a  in  6  ALU operand A
- in_b  in  6  ALU operand B
- in_opcode  in  3  ALU opcode
- in_result  in  6  ALU output under test
- in_last  in  1  marks the final record of a campaign
- busy  out  1  high in RUN or FLUSH
- done  out  1  high in DONE
- pass  out  1  done && fail_count==0
- test_count  out  CNT_W  records checked
- fail_count  out  CNT_W  mismatches
- first_fail_idx  out  CNT_W  test_count value at the first mismatch (0-based)
- first_fail_op  out  3  opcode of the first mismatch
- first_fail_exp  out  6  expected value of the first mismatch
- first_fail_act  out  6  actual value of the first mismatch
- err  out  1  sticky; set on any mismatch

## Operation
- Expected-value model; all arithmetic is 6-bit modulo 64:
  - 000: A
  - 001: B
  - 010: -A (two's complement, i.e. ~A+1)
  - 011: -B
  - 100: 6'b000001 if signed(A) < signed(B), else 6'b000000
  - 101: A XNOR B
  - 110: A+B
  - 111: A-B
- States and transitions:
  - IDLE → RUN on start.
  - RUN: in_ready=1. A transfer is in_valid && in_ready. A transfer with in_last=1 moves to FLUSH.
  - FLUSH: in_ready=0. Moves to DONE after one cycle.
  - DONE: holds all results. start → RUN, with a full clear.
  - start while in RUN or FLUSH is ignored.
- Pipeline, 2 stages:
  - S1 registers the transfer and its expected value.
  - S2 compares expected with actual, then increments test_count and, on mismatch, fail_count.
- On the first mismatch since start, latch first_fail_* and set err. Later mismatches never overwrite this record.
- Counters saturate at 2^CNT_W-1 and never wrap. first_fail_idx uses the pre-increment test_count.
- Records with in_valid=1 outside RUN are dropped and are not counted.

## Timing
- Reset values: state IDLE; in_ready, busy, done, pass, err = 0; all counters and first_fail_* = 0.
- start clears counters, err and first_fail_* on the same edge that enters RUN. in_ready is 1 from the next cycle.
- Transfer at edge k:
  - the compare result is reflected in test_count, fail_count and err after edge k+1;
  - back-to-back transfers every cycle are supported;
  - no bubbles are required.
- Last transfer at edge k:
  - state is FLUSH after edge k;
  - DONE after edge k+1, which is the same edge that counts the last record;
  - done, pass and final counts are therefore coherent in the first cycle done=1.
- rst mid-campaign returns to IDLE next edge. The in-flight S1 record is discarded and all outputs take reset values.
- Simultaneous start and in_valid in IDLE/DONE: start is taken; the record is dropped (in_ready was 0).

## Test plan
- Campaign of 3 correct records:
  - (011011, 011011, 110, 110110)
  - (100001, 011111, 111, 000010)
  - (100001, 000000, 010, 011111), in_last on the third
  - → done=1 two edges after the last transfer; test_count=3, fail_count=0, pass=1, err=0.
- Signed compare:
  - (011111, 100001, 100, 000000) and (100001, 011111, 100, 000001) both pass.
  - The same records with results swapped → fail_count=2; first_fail_idx=0, first_fail_op=100, first_fail_exp=000000, first_fail_act=000001.
- Record stream mixing failures:
  - records 0–1 correct;
  - record 2 is XNOR (101010, 010101) reporting 111111 (exp 000000);
  - record 4 is a wrong ADD;
  - → fail_count=2, first_fail_idx=2, first_fail_exp=000000, first_fail_act=111111.
- Handshake:
  - in_valid pulses in IDLE and DONE are ignored, with counts unchanged;
  - in_ready=0 in FLUSH;
  - start asserted in RUN has no effect on counts.
- Saturation with CNT_W=3: 10 correct records → test_count=7, no wrap, pass=1.
- Reset mid-campaign after 2 records including a failure → next cycle all outputs 0, state IDLE. A new start plus 1 correct last record → test_count=1, pass=1.

Source files
------------

// File: rtl/alu_result_checker_if.sv
// Record stream carrying {a, b, opcode, result, last} from the ALU side into the checker.
// The checker sits on the slave modport and owns in_ready.
interface alu_result_checker_if;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_a;
    logic [5:0] in_b;
    logic [2:0] in_opcode;
    logic [5:0] in_result;
    logic       in_last;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_opcode,
        output in_result,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_opcode,
        input  in_result,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/alu_result_checker.sv
// Hardware monitor for the 6-bit ALU: recomputes each streamed record, counts tests and
// failures with saturation, and latches the first mismatch for readout.
module alu_result_checker #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    alu_result_checker_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     test_count,
    output logic [CNT_W-1:0]     fail_count,
    output logic [CNT_W-1:0]     first_fail_idx,
    output logic [2:0]           first_fail_op,
    output logic [5:0]           first_fail_exp,
    output logic [5:0]           first_fail_act,
    output logic                 err
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e state_q, state_d;

    logic             in_ready;
    logic             xfer;
    logic             clear;
    logic             mismatch;
    logic [5:0]       exp_value;

    logic             s1_valid_q;
    logic [2:0]       s1_op_q;
    logic [5:0]       s1_exp_q;
    logic [5:0]       s1_act_q;

    logic [CNT_W-1:0] test_count_q;
    logic [CNT_W-1:0] fail_count_q;
    logic [CNT_W-1:0] first_fail_idx_q;
    logic [2:0]       first_fail_op_q;
    logic [5:0]       first_fail_exp_q;
    logic [5:0]       first_fail_act_q;
    logic             err_q;

    function automatic logic [5:0] alu_model(input logic [5:0] a, input logic [5:0] b,
                                             input logic [2:0] op);
        logic [5:0] r;
        unique case (op)
            3'b000:  r = a;
            3'b001:  r = b;
            3'b010:  r = ~a + 6'd1;
            3'b011:  r = ~b + 6'd1;
            3'b100:  r = ($signed(a) < $signed(b)) ? 6'd1 : 6'd0;
            3'b101:  r = ~(a ^ b);
            3'b110:  r = a + b;
            default: r = a - b;
        endcase
        return r;
    endfunction

    // Start is honoured only when no campaign is in flight.
    assign clear     = start && ((state_q == StIdle) || (state_q == StDone));
    assign xfer      = bus.in_valid && in_ready;
    assign exp_value = alu_model(bus.in_a, bus.in_b, bus.in_opcode);
    assign mismatch  = s1_exp_q != s1_act_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (xfer && bus.in_last) state_d = StFlush;
            StFlush: state_d = StDone;
            StDone:  if (start) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StRun: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            StFlush: busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
        pass = done && (fail_count_q == '0);
    end

    assign bus.in_ready = in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q       <= 1'b0;
            s1_op_q          <= '0;
            s1_exp_q         <= '0;
            s1_act_q         <= '0;
            test_count_q     <= '0;
            fail_count_q     <= '0;
            first_fail_idx_q <= '0;
            first_fail_op_q  <= '0;
            first_fail_exp_q <= '0;
            first_fail_act_q <= '0;
            err_q            <= 1'b0;
        end else begin
            s1_valid_q <= xfer;
            if (xfer) begin
                s1_op_q  <= bus.in_opcode;
                s1_exp_q <= exp_value;
                s1_act_q <= bus.in_result;
            end
            if (clear) begin
                test_count_q     <= '0;
                fail_count_q     <= '0;
                first_fail_idx_q <= '0;
                first_fail_op_q  <= '0;
                first_fail_exp_q <= '0;
                first_fail_act_q <= '0;
                err_q            <= 1'b0;
            end else if (s1_valid_q) begin
                if (test_count_q != CntMax) begin
                    test_count_q <= test_count_q + 1'b1;
                end
                if (mismatch) begin
                    if (fail_count_q != CntMax) begin
                        fail_count_q <= fail_count_q + 1'b1;
                    end
                    // Only the first mismatch since start is recorded.
                    if (!err_q) begin
                        first_fail_idx_q <= test_count_q;
                        first_fail_op_q  <= s1_op_q;
                        first_fail_exp_q <= s1_exp_q;
                        first_fail_act_q <= s1_act_q;
                        err_q            <= 1'b1;
                    end
                end
            end
        end
    end

    assign test_count     = test_count_q;
    assign fail_count     = fail_count_q;
    assign first_fail_idx = first_fail_idx_q;
    assign first_fail_op  = first_fail_op_q;
    assign first_fail_exp = first_fail_exp_q;
    assign first_fail_act = first_fail_act_q;
    assign err            = err_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed table-driven bench for alu_result_checker: an 8-bit-counter instance for the
// campaigns and a 3-bit-counter instance, fed the same stream, for saturation.
module tb_alu_result_checker;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic [2:0] op;
        logic [5:0] res;
        logic       first;
        logic       last;
        logic       start_in_run;
    } vec_t;

    typedef struct {
        int         tests;
        int         fails;
        logic [7:0] idx;
        logic [2:0] op;
        logic [5:0] exp_v;
        logic [5:0] act_v;
        logic       junk_start;
    } camp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       valid = 1'b0;
    logic [5:0] a = '0;
    logic [5:0] b = '0;
    logic [2:0] op = '0;
    logic [5:0] res = '0;
    logic       last = 1'b0;

    int n_tests = 0;
    int n_fails = 0;

    alu_result_checker_if bus8 ();
    alu_result_checker_if bus3 ();

    assign bus8.in_valid  = valid;
    assign bus8.in_a      = a;
    assign bus8.in_b      = b;
    assign bus8.in_opcode = op;
    assign bus8.in_result = res;
    assign bus8.in_last   = last;
    assign bus3.in_valid  = valid;
    assign bus3.in_a      = a;
    assign bus3.in_b      = b;
    assign bus3.in_opcode = op;
    assign bus3.in_result = res;
    assign bus3.in_last   = last;

    logic       busy8, done8, pass8, err8;
    logic [7:0] tc8, fc8, fidx8;
    logic [2:0] fop8;
    logic [5:0] fexp8, fact8;
    logic       busy3, done3, pass3, err3;
    logic [2:0] tc3, fc3, fidx3;
    logic [2:0] fop3;
    logic [5:0] fexp3, fact3;

    alu_result_checker #(.CNT_W(8)) dut8 (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .bus            (bus8),
        .busy           (busy8),
        .done           (done8),
        .pass           (pass8),
        .test_count     (tc8),
        .fail_count     (fc8),
        .first_fail_idx (fidx8),
        .first_fail_op  (fop8),
        .first_fail_exp (fexp8),
        .first_fail_act (fact8),
        .err            (err8)
    );

    alu_result_checker #(.CNT_W(3)) dut3 (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .bus            (bus3),
        .busy           (busy3),
        .done           (done3),
        .pass           (pass3),
        .test_count     (tc3),
        .fail_count     (fc3),
        .first_fail_idx (fidx3),
        .first_fail_op  (fop3),
        .first_fail_exp (fexp3),
        .first_fail_act (fact3),
        .err            (err3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t rec(input logic [5:0] va, input logic [5:0] vb,
                                 input logic [2:0] vop, input logic [5:0] vres,
                                 input logic vfirst, input logic vlast, input logic vsir);
        vec_t v;
        v.a = va; v.b = vb; v.op = vop; v.res = vres;
        v.first = vfirst; v.last = vlast; v.start_in_run = vsir;
        return v;
    endfunction

    function automatic camp_t camp(input int t, input int f, input logic [7:0] idx,
                                   input logic [2:0] cop, input logic [5:0] e,
                                   input logic [5:0] ac, input logic junk);
        camp_t c;
        c.tests = t; c.fails = f; c.idx = idx; c.op = cop;
        c.exp_v = e; c.act_v = ac; c.junk_start = junk;
        return c;
    endfunction

    // Start pulse; optionally with a wrong record offered on the same cycle, which must drop.
    task automatic start_campaign(input logic junk);
        @(negedge clk);
        start = 1'b1;
        valid = junk;
        a = 6'd1; b = 6'd0; op = 3'b000; res = 6'd2; last = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_start", bus8.in_ready, 1);
        chk("tc_cleared", tc8, 0);
        chk("err_cleared", err8, 0);
    endtask

    task automatic send(input vec_t v);
        @(negedge clk);
        start = v.start_in_run;
        valid = 1'b1;
        a = v.a; b = v.b; op = v.op; res = v.res; last = v.last;
        @(posedge clk);
    endtask

    task automatic finish_campaign(input camp_t e);
        @(negedge clk);
        valid = 1'b0; start = 1'b0; last = 1'b0;
        chk("flush_ready", bus8.in_ready, 0);
        chk("flush_busy", busy8, 1);
        chk("flush_done", done8, 0);
        @(negedge clk);
        chk("done", done8, 1);
        chk("busy_in_done", busy8, 0);
        chk("pass", pass8, (e.fails == 0) ? 1 : 0);
        chk("test_count", tc8, e.tests);
        chk("fail_count", fc8, e.fails);
        chk("err", err8, (e.fails != 0) ? 1 : 0);
        chk("first_fail_idx", fidx8, e.idx);
        chk("first_fail_op", fop8, e.op);
        chk("first_fail_exp", fexp8, e.exp_v);
        chk("first_fail_act", fact8, e.act_v);
        // A record offered in DONE must not be counted.
        valid = 1'b1;
        a = 6'd3; b = 6'd0; op = 3'b000; res = 6'd0;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        chk("done_drop_tc", tc8, e.tests);
        chk("done_drop_fc", fc8, e.fails);
    endtask

    vec_t  vecs[12];
    camp_t camps[4];

    initial begin
        int c;
        camp_t e;

        vecs[0]  = rec(6'b011011, 6'b011011, 3'b110, 6'b110110, 1, 0, 0);
        vecs[1]  = rec(6'b100001, 6'b011111, 3'b111, 6'b000010, 0, 0, 0);
        vecs[2]  = rec(6'b100001, 6'b000000, 3'b010, 6'b011111, 0, 1, 0);
        vecs[3]  = rec(6'b011111, 6'b100001, 3'b100, 6'b000000, 1, 0, 0);
        vecs[4]  = rec(6'b100001, 6'b011111, 3'b100, 6'b000001, 0, 1, 0);
        vecs[5]  = rec(6'b011111, 6'b100001, 3'b100, 6'b000001, 1, 0, 0);
        vecs[6]  = rec(6'b100001, 6'b011111, 3'b100, 6'b000000, 0, 1, 0);
        vecs[7]  = rec(6'b000101, 6'b000011, 3'b000, 6'b000101, 1, 0, 0);
        vecs[8]  = rec(6'b000101, 6'b000011, 3'b001, 6'b000011, 0, 0, 1);
        vecs[9]  = rec(6'b101010, 6'b010101, 3'b101, 6'b111111, 0, 0, 0);
        vecs[10] = rec(6'b000010, 6'b000011, 3'b011, 6'b111101, 0, 0, 0);
        vecs[11] = rec(6'b111111, 6'b000001, 3'b110, 6'b000001, 0, 1, 0);

        camps[0] = camp(3, 0, 8'd0, 3'b000, 6'b000000, 6'b000000, 0);
        camps[1] = camp(2, 0, 8'd0, 3'b000, 6'b000000, 6'b000000, 1);
        camps[2] = camp(2, 2, 8'd0, 3'b100, 6'b000000, 6'b000001, 0);
        camps[3] = camp(5, 2, 8'd2, 3'b101, 6'b000000, 6'b111111, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", bus8.in_ready, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_pass", pass8, 0);
        chk("rst_err", err8, 0);
        chk("rst_tc", tc8, 0);

        // Records offered in IDLE are dropped.
        valid = 1'b1;
        repeat (2) @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        chk("idle_drop_tc", tc8, 0);
        chk("idle_busy", busy8, 0);

        c = 0;
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].first) start_campaign(camps[c].junk_start);
            send(vecs[i]);
            if (vecs[i].last) begin
                finish_campaign(camps[c]);
                c++;
            end
        end

        // Saturation: 10 correct records; the 3-bit instance must stop at 7.
        start_campaign(0);
        for (int i = 0; i < 10; i++) begin
            send(rec(6'(i + 5), 6'd0, 3'b000, 6'(i + 5), 0, (i == 9), 0));
        end
        e = camp(10, 0, 8'd0, 3'b000, 6'b000000, 6'b000000, 0);
        finish_campaign(e);
        chk("sat_tc3", tc3, 7);
        chk("sat_fc3", fc3, 0);
        chk("sat_pass3", pass3, 1);

        // Reset with one failure counted and a record still in S1.
        start_campaign(0);
        send(rec(6'd1, 6'd0, 3'b000, 6'd2, 0, 0, 0));
        send(rec(6'd1, 6'd0, 3'b000, 6'd1, 0, 0, 0));
        #1;
        chk("pre_rst_err", err8, 1);
        chk("pre_rst_fc", fc8, 1);
        @(negedge clk);
        valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_tc", tc8, 0);
        chk("mid_rst_fc", fc8, 0);
        chk("mid_rst_err", err8, 0);
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_ready", bus8.in_ready, 0);
        chk("mid_rst_fidx", fidx8, 0);
        chk("mid_rst_fexp", fexp8, 0);
        chk("mid_rst_fact", fact8, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("s1_discarded_tc", tc8, 0);
        chk("post_rst_busy", busy8, 0);
        start_campaign(0);
        send(rec(6'b000111, 6'b000001, 3'b111, 6'b000110, 0, 1, 0));
        e = camp(1, 0, 8'd0, 3'b000, 6'b000000, 6'b000000, 0);
        finish_campaign(e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
